// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: load/store size
// codes, the arbiter state encoding and the captured data-operand record.
package mem_pkg;

  // Load/store size codes as driven by the core controller.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_FETCH_WAIT = 2'b01,
    ST_DATA_WAIT  = 2'b10
  } state_e;

  // Everything the WAIT cycle of a data access needs to finish the access
  // after the request inputs may have moved on.
  typedef struct packed {
    logic [1:0] addr_lo;
    logic [1:0] size;
    logic       zext;
    logic       load;
    logic       err;
  } data_op_t;

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering between the 32-bit memory word and the core: store
// byte enables, store data replication, load extraction with sign/zero
// extension, and detection of misaligned or illegal sizes.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] rdata_shifted;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};

  // Lane selection, replication and extension per access size.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h0, rdata_shifted[7:0]}
                             : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      end
      SZ_H: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = unsigned_i ? {16'h0, rdata_shifted[15:0]}
                                : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
        misalign_o = addr_lo_i[0];
      end
      SZ_W: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = |addr_lo_i;
      end
      default: begin
        // Size code 10 is not a legal access; it is reported as an error.
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction
// fetch and the load/store path. Each access takes exactly two cycles: the
// request cycle (memory enabled combinationally from the request) and a WAIT
// cycle in which the memory's registered read data is returned.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW     = 32,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [AW-1:0]     d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e   state_q, state_d;
  data_op_t op_q, op_d;

  logic [1:0]  la_size;
  logic [1:0]  la_addr_lo;
  logic        la_unsigned;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;
  logic        la_misalign;
  logic        req_err;
  logic        unused_addr_bits;

  // Byte address bits outside the memory's word range carry no meaning here.
  assign unused_addr_bits = ^{if_addr[AW-1:MEM_AW+2], if_addr[1:0],
                              d_addr[AW-1:MEM_AW+2]};

  // The single lane aligner serves the live request in IDLE and the captured
  // operands during the data WAIT cycle; the two uses never overlap.
  assign la_size     = (state_q == ST_DATA_WAIT) ? op_q.size    : d_size;
  assign la_addr_lo  = (state_q == ST_DATA_WAIT) ? op_q.addr_lo : d_addr[1:0];
  assign la_unsigned = (state_q == ST_DATA_WAIT) ? op_q.zext    : d_unsigned;

  lane_align u_lane_align (
    .size_i     (la_size),
    .addr_lo_i  (la_addr_lo),
    .unsigned_i (la_unsigned),
    .wdata_i    (d_wdata),
    .rdata_i    (mem_rdata),
    .be_o       (la_be),
    .wdata_o    (la_wdata),
    .rdata_o    (la_rdata),
    .misalign_o (la_misalign)
  );

  // Simultaneous load and store is treated as a faulting store.
  assign req_err = la_misalign | (d_rd & d_wr);

  // State and captured data operands; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Arbitration, memory drive and completion signalling.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if_valid  = 1'b0;
    if_rdata  = 32'h0;
    d_done    = 1'b0;
    d_err     = 1'b0;
    d_rdata   = 32'h0;

    case (state_q)
      ST_IDLE: begin
        // Data wins: it belongs to the instruction already executing.
        if (d_rd || d_wr) begin
          op_d.addr_lo = d_addr[1:0];
          op_d.size    = d_size;
          op_d.zext    = d_unsigned;
          op_d.load    = d_rd & ~d_wr;
          op_d.err     = req_err;
          if (!req_err) begin
            mem_en    = 1'b1;
            mem_we    = d_wr;
            mem_be    = la_be;
            mem_addr  = d_addr[MEM_AW+1:2];
            mem_wdata = d_wr ? la_wdata : 32'h0;
          end
          state_d = ST_DATA_WAIT;
        end else if (if_req) begin
          mem_en   = 1'b1;
          mem_addr = if_addr[MEM_AW+1:2];
          state_d  = ST_FETCH_WAIT;
        end
      end

      ST_FETCH_WAIT: begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
        state_d  = ST_IDLE;
      end

      ST_DATA_WAIT: begin
        // Faulting accesses never touched memory and return zero.
        d_done  = 1'b1;
        d_err   = op_q.err;
        d_rdata = (op_q.load && !op_q.err) ? la_rdata : 32'h0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Memory controls in IDLE follow the request inputs directly, so they
    // must be forced quiet while reset is asserted.
    if (!rstn) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = 32'h0;
    end
  end

  // Stall any requester whose held request is not completing this cycle.
  assign stall = rstn & (d_rd | d_wr | if_req) & ~(d_done | if_valid);

endmodule
